gcd_feeder: RTL

Upstream sequencer for the `gcd` core. It accepts operand pairs over a valid/ready input and buffers them in a small FIFO. It issues each pair to the core as a one-cycle START pulse, waits for the core's DONE, and presents the result and error flag on a valid/ready output. It sits between the operand source and `gcd`, so callers never have to hand-time START against DONE.

---
 rtl/gcd_feeder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gcd_feeder.sv
// gcd_feeder: operand-pair FIFO and START/DONE sequencer in front of the gcd core.
// Optional WAIT-state watchdog is built in when GCD_FEEDER_WATCHDOG_EN is defined.
module gcd_feeder #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [W-1:0]             IN_A,
  input  logic [W-1:0]             IN_B,
  output logic                     GCD_START,
  output logic [W-1:0]             GCD_A,
  output logic [W-1:0]             GCD_B,
  input  logic [W-1:0]             GCD_Y,
  input  logic                     GCD_DONE,
  input  logic                     GCD_ERROR,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [W-1:0]             OUT_Y,
  output logic                     OUT_ERR,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     BUSY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [2*W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            full, empty, push, pop;
  logic            done_q, done_rise, capture;
  logic [W-1:0]    gcd_a_q, gcd_b_q, out_y_q, out_y_d;
  logic            out_err_q, out_err_d;
  logic [2*W-1:0]  head;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign IN_READY  = !full && !RST;
  assign push      = IN_VALID && IN_READY;
  assign pop       = (state_q == StIdle) && !empty;
  assign head      = mem_q[rd_ptr_q];
  assign done_rise = GCD_DONE && !done_q;

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {IN_A, IN_B};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef GCD_FEEDER_WATCHDOG_EN
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wd_q;
  logic           wd_expire;

  // Zero throughout the first WAIT cycle, so expiry lands TIMEOUT cycles after entry.
  always_ff @(posedge CLK) begin
    if (RST || state_q != StWait) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign wd_expire = (wd_q == WD_LAST);
`else
  logic        wd_expire;
  logic [31:0] unused_timeout;

  assign wd_expire      = 1'b0;
  assign unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    out_y_d   = GCD_Y;
    out_err_d = GCD_ERROR;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        // A real DONE edge wins over a simultaneous timeout.
        if (done_rise) begin
          capture = 1'b1;
          state_d = StHold;
        end else if (wd_expire) begin
          capture   = 1'b1;
          out_y_d   = '0;
          out_err_d = 1'b1;
          state_d   = StHold;
        end
      end
      StHold:  if (OUT_READY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      gcd_a_q   <= '0;
      gcd_b_q   <= '0;
      out_y_q   <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= GCD_DONE;
      if (pop) begin
        gcd_a_q <= head[2*W-1:W];
        gcd_b_q <= head[W-1:0];
      end
      if (capture) begin
        out_y_q   <= out_y_d;
        out_err_q <= out_err_d;
      end
    end
  end

  assign GCD_START = (state_q == StIssue);
  assign GCD_A     = gcd_a_q;
  assign GCD_B     = gcd_b_q;
  assign OUT_VALID = (state_q == StHold);
  assign OUT_Y     = out_y_q;
  assign OUT_ERR   = out_err_q;
  assign COUNT     = count_q;
  assign BUSY      = (state_q != StIdle);

endmodule
